// File: rtl/insmem_loader.sv
// Boot-time instruction loader: assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory, then releases the core and watches fin.
// Optional build macro CHECKSUM_EN adds a trailing 8-bit checksum byte and a CSUM state.
module insmem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              pcclr,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  input  logic              cpu_fin,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both high.
  // in_ready is registered and depends only on state, never on in_valid.

  logic [2:0]        state, next_state;
  logic [7:0]        hdr_hi;
  logic              hdr_cnt;
  logic [1:0]        byte_idx;
  logic [23:0]       wbuf;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] word_idx;
  logic              fin_q;

  logic              xfer;
  logic              start_ok;
  logic [15:0]       hdr_n;
  logic              too_big;
  logic              word_done;
  logic              last_word;
  logic              fin_rise;

  assign xfer      = in_valid & in_ready;
  assign start_ok  = load_start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign hdr_n     = {hdr_hi, in_data};
  assign too_big   = {1'b0, hdr_n} > MAX_N;
  assign word_done = xfer && (state == S_LOAD) && (byte_idx == 2'd3);
  assign last_word = remaining == {{ADDR_W{1'b0}}, 1'b1};
  assign fin_rise  = cpu_fin & ~fin_q;
  assign state_dbg = state;

`ifdef CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  assign sum_next = sum + in_data;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start_ok) next_state = S_HDR;
      S_HDR: begin
        if (xfer && hdr_cnt) begin
          if (too_big) begin
            next_state = S_ERR;
          end else if (hdr_n == 16'd0) begin
`ifdef CHECKSUM_EN
            next_state = S_CSUM;
`else
            next_state = S_RUN;
`endif
          end else begin
            next_state = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (word_done && last_word) begin
`ifdef CHECKSUM_EN
          next_state = S_CSUM;
`else
          next_state = S_RUN;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: if (xfer) next_state = (sum_next == 8'd0) ? S_RUN : S_ERR;
`endif
      S_RUN:  if (fin_rise) next_state = S_DONE;
      S_DONE: if (start_ok) next_state = S_HDR;
      S_ERR:  if (start_ok) next_state = S_HDR;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge pcclr) begin
    if (!pcclr) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rstn   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      hdr_hi     <= '0;
      hdr_cnt    <= 1'b0;
      byte_idx   <= '0;
      wbuf       <= '0;
      remaining  <= '0;
      word_idx   <= '0;
      fin_q      <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == S_HDR) | (next_state == S_LOAD) | (next_state == S_CSUM);
      busy     <= (next_state == S_HDR) | (next_state == S_LOAD) | (next_state == S_CSUM);
      done     <= next_state == S_DONE;
      err      <= next_state == S_ERR;
      // The core only leaves reset one cycle after RUN is entered, so the final write lands first.
      cpu_rstn <= ((state == S_RUN) && (next_state == S_RUN)) || (next_state == S_DONE);
      imem_we  <= word_done;

      if (start_ok) begin
        word_idx <= '0;
        hdr_cnt  <= 1'b0;
        byte_idx <= '0;
        fin_q    <= 1'b0;
      end else begin
        fin_q <= cpu_fin;
        if (xfer && (state == S_HDR)) begin
          if (!hdr_cnt) begin
            hdr_hi  <= in_data;
            hdr_cnt <= 1'b1;
          end else begin
            remaining <= hdr_n[ADDR_W:0];
          end
        end
        if (xfer && (state == S_LOAD)) begin
          wbuf     <= {wbuf[15:0], in_data};
          byte_idx <= byte_idx + 2'd1;
        end
        if (word_done) begin
          imem_wdata <= {wbuf, in_data};
          imem_addr  <= word_idx;
          word_idx   <= word_idx + 1'b1;
          remaining  <= remaining - 1'b1;
        end
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk or negedge pcclr) begin
    if (!pcclr) begin
      sum <= '0;
    end else if (start_ok) begin
      sum <= '0;
    end else if (xfer) begin
      sum <= sum_next;
    end
  end
`endif

endmodule
